// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter.
// UART_TX_ARBITER_ID_HDR_EN adds the S_HDR state for requester-ID framing.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam logic [7:0]  HDR_TAG = 8'hA0;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
`ifdef UART_TX_ARBITER_ID_HDR_EN
    S_WAIT  = 3'd3,
    S_HDR   = 3'd4
`else
    S_WAIT  = 3'd3
`endif
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin find-first: first set request searching upward from ptr+1, modulo N.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            any_valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [ID_W:0]  shift;
  int unsigned    off;

  // Rotate so ptr+1 lands at bit 0, pick lowest set bit, then unrotate.
  always_comb begin
    dbl   = {req, req};
    shift = (ID_W+1)'(ptr) + (ID_W+1)'(1);
    rot   = N'(dbl >> shift);
    off   = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) off = 32'(i);
    end
    winner    = ID_W'((32'(ptr) + 32'd1 + off) % N);
    any_valid = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin sharing of one uart_tx between NUM_REQ byte streams.
// Define UART_TX_ARBITER_ID_HDR_EN to prefix each message with 8'hA0 | grant_id.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = $clog2(NUM_REQ),
  parameter int unsigned MAX_MSG_LEN = 64,
  parameter int unsigned LEN_WIDTH   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*8-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_finish,
  output logic                  busy,
  output logic [ID_WIDTH-1:0]   grant_id,
  output logic                  trunc
);

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d, grant_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 hdr_q, hdr_d;
  logic [7:0]           data_d;
  logic                 trunc_d;
  logic [7:0]           sel_data;
  logic                 sel_last;
  logic [ID_WIDTH-1:0]  win;
  logic                 any_valid;
  logic                 limit_hit;

  rr_pick #(.N(NUM_REQ), .ID_W(ID_WIDTH)) u_rr_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .winner    (win),
    .any_valid (any_valid)
  );

  assign limit_hit = (MAX_MSG_LEN != 0) && (cnt_q == LEN_WIDTH'(MAX_MSG_LEN));

  // Next-state, byte latch and counter control.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_id;
    cnt_d    = cnt_q;
    last_d   = last_q;
    hdr_d    = hdr_q;
    data_d   = tx_data;
    trunc_d  = 1'b0;
    sel_data = 8'h00;
    sel_last = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant_d = win;
          cnt_d   = '0;
`ifdef UART_TX_ARBITER_ID_HDR_EN
          state_d = S_HDR;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef UART_TX_ARBITER_ID_HDR_EN
      S_HDR: begin
        data_d  = HDR_TAG | 8'(grant_id);
        hdr_d   = 1'b1;
        last_d  = 1'b0;
        state_d = S_START;
      end
`endif
      S_FETCH: begin
        if (req_valid[grant_id]) begin
          data_d  = sel_data;
          last_d  = sel_last;
          hdr_d   = 1'b0;
          if (cnt_q != {LEN_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_finish) begin
          if (hdr_q) begin
            state_d = S_FETCH;
          end else if (last_q || limit_hit) begin
            ptr_d   = grant_id;
            trunc_d = ~last_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= ID_WIDTH'(NUM_REQ - 1);
      cnt_q     <= '0;
      last_q    <= 1'b0;
      hdr_q     <= 1'b0;
      req_ready <= '0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
      trunc     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      hdr_q     <= hdr_d;
      req_ready <= (state_d == S_FETCH) ? (NUM_REQ'(1) << grant_d) : '0;
      tx_data   <= data_d;
      tx_start  <= (state_d == S_START);
      busy      <= (state_d != S_IDLE);
      grant_id  <= grant_d;
      trunc     <= trunc_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_tx` byte transmitter between NUM_REQ independent byte-stream requesters.
- Arbitrates round-robin at message granularity (`req_last` delimits a message) and sequences the `start`/`finish` handshake for every byte.
- Optionally prefixes each message with a requester-ID header byte.
- Sits between the breakout's status/telemetry sources and the single host UART line.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_WIDTH, $clog2(NUM_REQ), width of `grant_id`.
- MAX_MSG_LEN, 64, maximum bytes per grant before forced release; 0 = unlimited.
- LEN_WIDTH, 7, width of the per-grant byte counter; must hold MAX_MSG_LEN.

Ports:
- clk  in  1  system clock; same clock as `uart_tx`.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a message.
- req_ready  out  NUM_REQ  byte accepted when valid & ready.
- tx_data  out  8  to `uart_tx` data.
- tx_start  out  1  to `uart_tx` start; single-cycle pulse.
- tx_finish  in  1  from `uart_tx` finish.
- busy  out  1  high whenever state is not S_IDLE.
- grant_id  out  ID_WIDTH  index of the current owner; valid while busy.
- trunc  out  1  one-cycle pulse when a grant is force-released by MAX_MSG_LEN.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: state = S_IDLE, `req_ready` = 0, `tx_data` = 8'h00, `tx_start` = 0, `busy` = 0, `grant_id` = 0, `trunc` = 0.
  - Internals: round-robin pointer = NUM_REQ-1, so requester 0 wins first; byte counter = 0.
  - Reset mid-message abandons the message. An in-flight `uart_tx` byte completes on its own; the resulting `tx_finish` is ignored because state is S_IDLE.
- States: S_IDLE, S_FETCH, S_START, S_WAIT, S_HDR (S_HDR exists only with the optional feature).
- S_IDLE:
  - If any `req_valid`, pick the first asserted index searching upward from pointer+1, modulo NUM_REQ.
  - Register it as `grant_id`, clear the byte counter, go to S_FETCH.
- S_FETCH:
  - `req_ready[grant_id]` = 1; all other `req_ready` bits = 0. `req_ready` is decoded from registered state only.
  - On `req_valid[grant_id]`: latch the byte into `tx_data`, latch `req_last`, increment the counter, go to S_START.
  - If valid is low, stay in S_FETCH indefinitely; the grant is held and no other requester may interleave mid-message.
- S_START:
  - `tx_start` = 1 for exactly this cycle; `tx_data` stays stable. Next state is S_WAIT.
- S_WAIT:
  - `tx_data` is held until `tx_finish`.
  - On `tx_finish`, if latched last = 1, or MAX_MSG_LEN != 0 and counter == MAX_MSG_LEN: set pointer = `grant_id` and go to S_IDLE.
    - In the forced-release case without last, pulse `trunc` for one cycle.
  - Otherwise go to S_FETCH.
- `tx_finish` outside S_WAIT is ignored.
- Latency:
  - `req_valid` seen in S_IDLE at cycle t: `req_ready` is high at t+1; if valid at t+1, `tx_start` is high at t+2.
  - After `tx_finish` at cycle f with more bytes pending, the next `tx_start` is no earlier than f+2.
- Simultaneous requests are resolved by the round-robin pointer only. A requester that just released has the lowest priority next.
- Counter arithmetic is unsigned and saturates at its maximum; it never wraps within a grant.

Optional Feature:
- Macro: UART_TX_ARBITER_ID_HDR_EN.
- Defined:
  - S_IDLE goes to S_HDR instead of S_FETCH.
  - S_HDR loads `tx_data` = 8'hA0 | `grant_id`, then follows S_START → S_WAIT.
  - That S_WAIT returns to S_FETCH on `tx_finish`.
  - The header does not count toward MAX_MSG_LEN and is never treated as last.
- Undefined: S_HDR is absent; messages go to the wire unframed.

Decomposition:
- Package `uart_arb_pkg`:
  - state encoding localparams;
  - HDR_TAG = 8'hA0;
  - requester-count limit 16.
- Sub-module `rr_pick`:
  - combinational rotate, find-first and unrotate over NUM_REQ bits;
  - inputs: request vector and pointer;
  - outputs: winner index and any_valid.
- The FSM, byte latch and counter stay in `uart_tx_arbiter`.

Test Plan:
- Single message: req0 sends 0x55, 0x AA(last) with `uart_tx` at CYCLES_PER_BIT=10 → wire shows 0x55 then 0xAA; `tx_start` 2 cycles after first valid; `busy` drops 1 cycle after the second `tx_finish`.
- Contention: req1 and req3 each sending 3-byte messages, both valid from reset → req1's bytes complete before any req3 byte; then req3's bytes; the rr pointer ends at 3.
- Stall mid-message: req2 drops valid for 50 cycles after byte 1 while req0 is valid → `grant_id` stays 2, `req_ready[0]` stays 0, and req0 is served only after req2's last byte.
- Truncation: MAX_MSG_LEN=4, req0 streams 6 bytes with last on byte 6 → `trunc` pulses after byte 4, req1 (pending) is served next, then req0 resumes with bytes 5-6.
- Reset mid-WAIT: assert `reset` for 1 cycle during byte 2 → all outputs at reset values; the late `tx_finish` is ignored; the next grant goes to requester 0.
- With UART_TX_ARBITER_ID_HDR_EN: req3 sends 0x11(last) → wire shows 0xA3 then 0x11; a one-byte message is not truncated at MAX_MSG_LEN=1 (the header does not count).
